key_conditioner: RTL and testbench

//  Upstream input-conditioning stage between the raw DE0-Nano push-buttons and the tail-light FSM.
//  - Synchronises each KEY into the clk domain and debounces it.
//  - Produces a clean level, 1-cycle press/release pulses, and a sticky press flag.
//  - The sticky flag is held until the slow FSM sample point (tick), so no press is lost.

---
 rtl/key_conditioner_pkg.sv | 11 +
 rtl/key_conditioner_if.sv | 29 ++
 rtl/key_conditioner_debounce_cell.sv | 71 +++++++
 rtl/key_conditioner.sv | 30 +++
 tb/tb_key_conditioner.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared constants and helpers for the push-button conditioning stage.
package key_pkg;

    localparam int DB_CYCLES_DEFAULT = 1000000;

    // Counter width able to hold values 0..n
    function automatic int db_width(int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Bundle of raw key inputs, the slow-FSM tick and the conditioned key outputs.
interface key_conditioner_if #(
    parameter int N_KEYS = 2
);
    logic [N_KEYS-1:0] key_raw;
    logic              tick;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_latched;

    modport master (
        output key_raw,
        output tick,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_latched
    );

    modport slave (
        input  key_raw,
        input  tick,
        output key_level,
        output key_press,
        output key_release,
        output key_latched
    );
endinterface

// File: rtl/key_conditioner_debounce_cell.sv
// One key: two-flop synchroniser, debounce counter, level, edge pulses and sticky press flag.
module debounce_cell
    import key_pkg::*;
#(
    parameter int DB_CYCLES      = DB_CYCLES_DEFAULT,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_latched
);
    localparam int             CNT_W    = db_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic           IDLE_RAW = KEY_ACTIVE_LOW;

    logic             sync_meta;
    logic             sync_out;
    logic             pressed;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= IDLE_RAW;
            sync_out  <= IDLE_RAW;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    assign pressed = KEY_ACTIVE_LOW ? ~sync_out : sync_out;

    // Pulses fire on the same edge that the new level is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (pressed == key_level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                key_level   <= pressed;
                cnt         <= '0;
                key_press   <= pressed;
                key_release <= ~pressed;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_latched <= 1'b0;
        end else if (key_press) begin
            key_latched <= 1'b1;
        end else if (tick) begin
            key_latched <= 1'b0;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Conditions each raw push-button independently; the top only fans key_raw and tick out to the cells.
module key_conditioner
    import key_pkg::*;
#(
    parameter int N_KEYS         = 2,
    parameter int DB_CYCLES      = DB_CYCLES_DEFAULT,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input logic         clk,
    input logic         reset,
    key_conditioner_if.slave keys
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        debounce_cell #(
            .DB_CYCLES     (DB_CYCLES),
            .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .raw        (keys.key_raw[i]),
            .tick       (keys.tick),
            .key_level  (keys.key_level[i]),
            .key_press  (keys.key_press[i]),
            .key_release(keys.key_release[i]),
            .key_latched(keys.key_latched[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DB_CYCLES=8 and active-low keys.
module tb_key_conditioner;

    logic clk;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;
    int press_cnt[2];
    int rel_cnt[2];
    int coincide    = 0;
    int p0;
    int r0;
    logic quiet_bad;

    key_conditioner_if #(.N_KEYS(2)) kif ();

    key_conditioner #(
        .N_KEYS        (2),
        .DB_CYCLES     (8),
        .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .keys (kif)
    );

    // 100 MHz-style free-running clock; rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (kif.key_press[i])   press_cnt[i] = press_cnt[i] + 1;
            if (kif.key_release[i]) rel_cnt[i]   = rel_cnt[i] + 1;
            if (kif.key_press[i] && kif.key_release[i]) coincide = coincide + 1;
        end
    end

    task automatic applyStimulus(input logic [1:0] raw, input logic t);
        kif.key_raw = raw;
        kif.tick    = t;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors = vectors + 1;
        if (observed !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseTick(input logic [1:0] raw);
        applyStimulus(raw, 1'b1);
        step(1);
        applyStimulus(raw, 1'b0);
    endtask

    initial begin
        press_cnt[0] = 0; press_cnt[1] = 0;
        rel_cnt[0]   = 0; rel_cnt[1]   = 0;
        quiet_bad    = 1'b0;
        reset = 1'b0;
        applyStimulus(2'b10, 1'b0);

        // Reset held with key0 pressed: every output stays low
        step(3);
        checkOutput("rst_level",   kif.key_level,   2'b00);
        checkOutput("rst_press",   kif.key_press,   2'b00);
        checkOutput("rst_release", kif.key_release, 2'b00);
        checkOutput("rst_latched", kif.key_latched, 2'b00);

        reset = 1'b1;
        step(9);
        checkOutput("t1_level_edge9",  kif.key_level, 2'b00);
        step(1);
        checkOutput("t1_level_edge10", kif.key_level, 2'b01);
        checkOutput("t1_press_edge10", kif.key_press, 2'b01);
        step(1);
        checkOutput("t1_press_edge11", kif.key_press,   2'b00);
        checkOutput("t1_latched",      kif.key_latched, 2'b01);

        applyStimulus(2'b11, 1'b0);
        step(10);
        checkOutput("t1_rel_level", kif.key_level,   2'b00);
        checkOutput("t1_rel_pulse", kif.key_release, 2'b01);
        pulseTick(2'b11);
        checkOutput("t1_tick_clear", kif.key_latched, 2'b00);

        // Bounce: 3-cycle runs never reach the 8-cycle threshold
        step(3);
        p0 = press_cnt[0];
        for (int seg = 0; seg < 10; seg++) begin
            applyStimulus({1'b1, (seg % 2 == 1)}, 1'b0);
            repeat (3) begin
                step(1);
                if (kif.key_level !== 2'b00 || kif.key_press !== 2'b00 || kif.key_release !== 2'b00)
                    quiet_bad = 1'b1;
            end
        end
        applyStimulus(2'b10, 1'b0);
        repeat (9) begin
            step(1);
            if (kif.key_level !== 2'b00 || kif.key_press !== 2'b00) quiet_bad = 1'b1;
        end
        checkOutput("t2_bounce_quiet", quiet_bad, 1'b0);
        step(1);
        checkOutput("t2_level_settle", kif.key_level, 2'b01);
        checkOutput("t2_press_settle", kif.key_press, 2'b01);
        step(1);
        checkOutput("t2_press_count", press_cnt[0] - p0, 1);

        // Clean press held 20 cycles, then clean release
        applyStimulus(2'b11, 1'b0);
        step(12);
        pulseTick(2'b11);
        p0 = press_cnt[0];
        r0 = rel_cnt[0];
        applyStimulus(2'b10, 1'b0);
        step(10);
        checkOutput("t3_level_up", kif.key_level, 2'b01);
        checkOutput("t3_press",    kif.key_press, 2'b01);
        step(10);
        applyStimulus(2'b11, 1'b0);
        step(9);
        checkOutput("t3_level_held", kif.key_level, 2'b01);
        step(1);
        checkOutput("t3_level_down", kif.key_level,   2'b00);
        checkOutput("t3_release",    kif.key_release, 2'b01);
        step(1);
        checkOutput("t3_press_count",   press_cnt[0] - p0, 1);
        checkOutput("t3_release_count", rel_cnt[0] - r0,   1);

        // Sticky flag: cleared by tick while held; press beats a coincident tick
        pulseTick(2'b11);
        checkOutput("t4_tick_clear", kif.key_latched, 2'b00);
        pulseTick(2'b11);
        checkOutput("t4_tick_idle", kif.key_latched, 2'b00);
        applyStimulus(2'b10, 1'b0);
        step(10);
        checkOutput("t4_press", kif.key_press, 2'b01);
        step(1);
        checkOutput("t4_latched_set", kif.key_latched, 2'b01);
        step(5);
        checkOutput("t4_latched_hold", kif.key_latched, 2'b01);
        pulseTick(2'b10);
        checkOutput("t4_latched_clr",  kif.key_latched, 2'b00);
        checkOutput("t4_still_held",   kif.key_level,   2'b01);
        applyStimulus(2'b11, 1'b0);
        step(12);
        applyStimulus(2'b10, 1'b0);
        step(10);
        checkOutput("t4_press2", kif.key_press, 2'b01);
        pulseTick(2'b10);
        checkOutput("t4_press_wins", kif.key_latched, 2'b01);

        // Reset mid-debounce abandons the count; held key re-detected after release
        applyStimulus(2'b11, 1'b0);
        step(12);
        pulseTick(2'b11);
        applyStimulus(2'b10, 1'b0);
        step(5);
        checkOutput("t5_cnt_pre", 32'(dut.g_key[0].u_cell.cnt), 3);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("t5_cnt_rst",     32'(dut.g_key[0].u_cell.cnt), 0);
        checkOutput("t5_level_rst",   kif.key_level,   2'b00);
        checkOutput("t5_press_rst",   kif.key_press,   2'b00);
        checkOutput("t5_latched_rst", kif.key_latched, 2'b00);
        p0 = press_cnt[0];
        step(3);
        checkOutput("t5_no_press", press_cnt[0] - p0, 0);
        reset = 1'b1;
        step(9);
        checkOutput("t5_redetect_pre", kif.key_level, 2'b00);
        step(1);
        checkOutput("t5_redetect_lvl", kif.key_level, 2'b01);
        checkOutput("t5_redetect_prs", kif.key_press, 2'b01);

        // Both keys pressed on the same edge
        applyStimulus(2'b11, 1'b0);
        step(12);
        pulseTick(2'b11);
        applyStimulus(2'b00, 1'b0);
        step(10);
        checkOutput("t6_press_both", kif.key_press, 2'b11);
        checkOutput("t6_level_both", kif.key_level, 2'b11);
        step(1);
        checkOutput("t6_latched_both", kif.key_latched, 2'b11);
        checkOutput("t6_press_done",   kif.key_press,   2'b00);
        checkOutput("t6_key1_count",   press_cnt[1], 1);

        checkOutput("no_coincident_pulses", coincide, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
